mdu: RTL and testbench

Iterative multiply/divide unit holding the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the `mips` datapath: it takes its operands from GPR read ports 1 and 2 and feeds HI/LO back into the GPR write-data mux for MFHI/MFLO. It asserts `busy` so the controller can stall the IFU while an operation is in flight.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_divider.sv | 72 +++++++
 rtl/mdu.sv | 166 ++++++++++++++++
 tb/tb_mdu.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants and helpers for the multiply/divide unit: opcodes and
// sign-magnitude conversion used by the signed MULT/DIV paths.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    function automatic logic [XLEN-1:0] mag32(input logic signed [XLEN-1:0] v,
                                              input logic is_signed);
        if (is_signed && (v < 0))
            return XLEN'(-v);
        return v;
    endfunction

    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// done and the results are combinational on the final iteration cycle.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int ITER_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(ITER_CYCLES);

    logic            active;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    // quo_q starts as the dividend and shifts out into the partial remainder
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        if (!diff[XLEN+1]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    assign done      = active && (cnt == CW'(ITER_CYCLES - 1));
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start && !active) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + CW'(1);
            if (done)
                active <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start && !active) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (active) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit holding HI/LO; iterative shift-add multiply and restoring divide.
// Define MDU_FAST_MUL_EN for a single-cycle combinational MULT/MULTU.
module mdu
    import mdu_pkg::*;
#(
    parameter int ITER_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t            state;
    state_t            state_next;
    logic              is_mul;
    logic              is_div;
    logic              is_signed;
    logic              launch;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   rs_raw_q;
    logic [2*XLEN-1:0] prod_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              div_zero_q;
    logic              mul_last;
    logic [2*XLEN-1:0] mul_raw;
    logic [2*XLEN-1:0] mul_res;
    logic              div_done;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;

    always_comb begin
        is_mul    = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
        is_div    = (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
        is_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
        launch    = (state == S_IDLE) && start;
        rs_mag    = mag32(rs_data, is_signed);
        rt_mag    = mag32(rt_data, is_signed);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && is_mul)
                    state_next = S_MUL;
                else if (start && is_div)
                    state_next = S_DIV;
            end
            S_MUL:   if (mul_last) state_next = S_IDLE;
            S_DIV:   if (div_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Operands are held as magnitudes; signs are reapplied at completion
    always_ff @(posedge clk) begin
        if (launch && (is_mul || is_div)) begin
            a_q        <= rs_mag;
            rs_raw_q   <= rs_data;
            neg_res_q  <= is_signed && (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
            neg_rem_q  <= is_signed && rs_data[XLEN-1];
            div_zero_q <= (rt_data == '0);
        end
    end

`ifdef MDU_FAST_MUL_EN
    assign mul_last = 1'b1;
    assign mul_raw  = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, prod_q[XLEN-1:0]};

    always_ff @(posedge clk) begin
        if (launch && is_mul)
            prod_q <= {{XLEN{1'b0}}, rt_mag};
    end
`else
    localparam int CW = $clog2(ITER_CYCLES);

    logic [CW-1:0] cnt;
    logic [XLEN:0] mul_sum;

    // prod_q low half holds the remaining multiplier bits, LSB first
    always_comb begin
        mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                  (prod_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    end

    assign mul_raw  = {mul_sum, prod_q[XLEN-1:1]};
    assign mul_last = (cnt == CW'(ITER_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (launch)
            cnt <= '0;
        else if (state == S_MUL)
            cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (launch && is_mul)
            prod_q <= {{XLEN{1'b0}}, rt_mag};
        else if (state == S_MUL)
            prod_q <= mul_raw;
    end
`endif

    assign mul_res = neg_res_q ? neg64(mul_raw) : mul_raw;

    mdu_divider #(
        .ITER_CYCLES (ITER_CYCLES)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (launch && is_div),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Divide by zero bypasses sign correction and returns the raw dividend
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (launch && (op == MDU_OP_MTHI)) begin
            hi <= rs_data;
        end else if (launch && (op == MDU_OP_MTLO)) begin
            lo <= rs_data;
        end else if ((state == S_MUL) && mul_last) begin
            hi <= mul_res[2*XLEN-1:XLEN];
            lo <= mul_res[XLEN-1:0];
        end else if ((state == S_DIV) && div_done) begin
            if (div_zero_q) begin
                hi <= rs_raw_q;
                lo <= '1;
            end else begin
                hi <= neg_rem_q ? neg32(div_rem) : div_rem;
                lo <= neg_res_q ? neg32(div_quo) : div_quo;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: multiply, divide, edge cases, moves, reset abort.
module tb_mdu;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 32;
`endif
    localparam int DIV_CYC = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail = 0;

    mdu #(.ITER_CYCLES(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launches op, counts busy cycles, pokes an ignored MTHI mid-flight and checks HI/LO hold
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        prev_hi = hi;
        prev_lo = lo;
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (cyc == 5) begin
                start = 1'b1; op = MDU_OP_MTHI; rs_data = 32'h5555_5555;
            end else begin
                start = 1'b0;
            end
            if (cyc == 10) begin
                check_eq({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, prev_hi});
                check_eq({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, prev_lo});
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;

        #12;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_hi", {32'd0, hi}, 64'd0);
        check_eq("rst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check_eq("multu_max_cyc", 64'(cyc), 64'(MUL_CYC));
        check_eq("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op("mult_neg", MDU_OP_MULT, 32'hFFFF_FFF9, 32'd3, cyc);
        check_eq("mult_neg_cyc", 64'(cyc), 64'(MUL_CYC));
        check_eq("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("div_neg", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        check_eq("div_neg_cyc", 64'(cyc), 64'(DIV_CYC));
        check_eq("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("divu", MDU_OP_DIVU, 32'd100, 32'd7, cyc);
        check_eq("divu_cyc", 64'(cyc), 64'(DIV_CYC));
        check_eq("divu_hilo", {hi, lo}, {32'd2, 32'd14});

        run_op("divu_zero", MDU_OP_DIVU, 32'd5, 32'd0, cyc);
        check_eq("divu_zero_cyc", 64'(cyc), 64'(DIV_CYC));
        check_eq("divu_zero_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

        run_op("div_zero", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd0, cyc);
        check_eq("div_zero_hilo", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

        run_op("div_ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check_eq("div_ovf_cyc", 64'(cyc), 64'(DIV_CYC));
        check_eq("div_ovf_hilo", {hi, lo}, {32'd0, 32'h8000_0000});

        @(negedge clk);
        op = MDU_OP_MTHI; rs_data = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        check_eq("mthi_busy", {63'd0, busy}, 64'd0);
        check_eq("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEAD_BEEF});
        op = MDU_OP_MTLO; rs_data = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        check_eq("mtlo_busy", {63'd0, busy}, 64'd0);
        check_eq("mtlo_hilo", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});

        @(negedge clk);
        op = MDU_OP_DIVU; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("abort_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_small", MDU_OP_MULTU, 32'd3, 32'd4, cyc);
        check_eq("multu_small_cyc", 64'(cyc), 64'(MUL_CYC));
        check_eq("multu_small_hilo", {hi, lo}, 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
